// File: rtl/super_pkg.sv
// Shared decode definitions: opcode encoding, instruction field positions
// and the ID/EX control bundle.
package super_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_ADD   = 4'd1,
        OP_SUB   = 4'd2,
        OP_XOR   = 4'd3,
        OP_ADDI  = 4'd4,
        OP_LOAD  = 4'd5,
        OP_STORE = 4'd6,
        OP_BEQ   = 4'd7,
        OP_JMP   = 4'd8
    } opcode_e;

    localparam int unsigned FIELD_W = 4;
    localparam int unsigned OPC_LSB = 12;
    localparam int unsigned RD_LSB  = 8;
    localparam int unsigned RS1_LSB = 4;
    localparam int unsigned RS2_LSB = 0;

    typedef struct packed {
        logic reg_we;
        logic mem_rd;
        logic mem_wr;
        logic branch;
        logic jump;
        logic illegal;
    } idex_ctrl_t;

    function automatic idex_ctrl_t decode_ctrl(input logic [3:0] op);
        idex_ctrl_t c;
        c = '0;
        case (op)
            OP_NOP:                          ;
            OP_ADD, OP_SUB, OP_XOR, OP_ADDI: c.reg_we = 1'b1;
            OP_LOAD:                         begin c.reg_we = 1'b1; c.mem_rd = 1'b1; end
            OP_STORE:                        c.mem_wr = 1'b1;
            OP_BEQ:                          c.branch = 1'b1;
            OP_JMP:                          c.jump = 1'b1;
            default:                         c.illegal = 1'b1;
        endcase
        return c;
    endfunction

    // Only these opcodes actually read the rs2 field as a register index.
    function automatic logic uses_rs2(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_XOR) ||
               (op == OP_STORE) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/super_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port,
// r0 hardwired to zero. DECODE_BYPASS_EN forwards same-cycle write data.
module super_regfile
    import super_pkg::*;
#(
    parameter int unsigned REGI_BITS = 4,
    parameter int unsigned REGI_SIZE = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [REGI_BITS-1:0] rs1_addr_i,
    input  logic [REGI_BITS-1:0] rs2_addr_i,
    output logic [REGI_SIZE-1:0] rs1_data_o,
    output logic [REGI_SIZE-1:0] rs2_data_o,
    input  logic                 wb_en_i,
    input  logic [REGI_BITS-1:0] wb_addr_i,
    input  logic [REGI_SIZE-1:0] wb_data_i
);

    localparam int unsigned DEPTH = 2 ** REGI_BITS;

    logic [REGI_SIZE-1:0] regs [DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en_i && (wb_addr_i != '0)) begin
            regs[wb_addr_i] <= wb_data_i;
        end
    end

    always_comb begin
        rs1_data_o = '0;
        if (rs1_addr_i != '0) begin
`ifdef DECODE_BYPASS_EN
            if (wb_en_i && (wb_addr_i == rs1_addr_i)) rs1_data_o = wb_data_i;
            else                                      rs1_data_o = regs[rs1_addr_i];
`else
            rs1_data_o = regs[rs1_addr_i];
`endif
        end
    end

    always_comb begin
        rs2_data_o = '0;
        if (rs2_addr_i != '0) begin
`ifdef DECODE_BYPASS_EN
            if (wb_en_i && (wb_addr_i == rs2_addr_i)) rs2_data_o = wb_data_i;
            else                                      rs2_data_o = regs[rs2_addr_i];
`else
            rs2_data_o = regs[rs2_addr_i];
`endif
        end
    end

endmodule

// File: rtl/super_decode.sv
// Decode stage: field extraction, immediate generation, load-use hazard
// detection and the ID/EX pipeline register. Optional macro: DECODE_BYPASS_EN.
module super_decode
    import super_pkg::*;
#(
    parameter int unsigned REGI_BITS = 4,
    parameter int unsigned REGI_SIZE = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [REGI_SIZE-1:0] next_pc_i,
    input  logic [REGI_SIZE-1:0] instr_i,
    input  logic                 flush_i,
    input  logic                 wb_en_i,
    input  logic [REGI_BITS-1:0] wb_addr_i,
    input  logic [REGI_SIZE-1:0] wb_data_i,
    output logic                 stall_o,
    output logic                 valid_o,
    output logic [3:0]           op_o,
    output logic [REGI_BITS-1:0] rd_o,
    output logic [REGI_BITS-1:0] rs1_addr_o,
    output logic [REGI_BITS-1:0] rs2_addr_o,
    output logic [REGI_SIZE-1:0] rs1_data_o,
    output logic [REGI_SIZE-1:0] rs2_data_o,
    output logic [REGI_SIZE-1:0] imm_o,
    output logic [REGI_SIZE-1:0] next_pc_o,
    output logic                 reg_we_o,
    output logic                 mem_rd_o,
    output logic                 mem_wr_o,
    output logic                 branch_o,
    output logic                 jump_o,
    output logic                 illegal_o
);

    logic [3:0]           op;
    logic [REGI_BITS-1:0] rd, rs1, rs2;
    logic [3:0]           imm4;
    logic [7:0]           imm8;
    logic [REGI_SIZE-1:0] imm;
    logic [REGI_SIZE-1:0] rs1_data, rs2_data;
    idex_ctrl_t           ctrl_d, ctrl_q;
    logic                 hazard, bubble;

    assign op   = instr_i[OPC_LSB +: FIELD_W];
    assign rd   = instr_i[RD_LSB  +: REGI_BITS];
    assign rs1  = instr_i[RS1_LSB +: REGI_BITS];
    assign rs2  = instr_i[RS2_LSB +: REGI_BITS];
    assign imm4 = instr_i[RS2_LSB +: 4];
    assign imm8 = instr_i[RS2_LSB +: 8];

    super_regfile #(
        .REGI_BITS (REGI_BITS),
        .REGI_SIZE (REGI_SIZE)
    ) u_regfile (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rs1_addr_i (rs1),
        .rs2_addr_i (rs2),
        .rs1_data_o (rs1_data),
        .rs2_data_o (rs2_data),
        .wb_en_i    (wb_en_i),
        .wb_addr_i  (wb_addr_i),
        .wb_data_i  (wb_data_i)
    );

    always_comb begin
        ctrl_d = decode_ctrl(op);
        imm    = '0;
        case (op)
            OP_ADDI, OP_LOAD, OP_STORE, OP_BEQ: imm = {{(REGI_SIZE-4){imm4[3]}}, imm4};
            OP_JMP:                             imm = {{(REGI_SIZE-8){imm8[7]}}, imm8};
            default:                            imm = '0;
        endcase
    end

    // Hazard looks at the held ID/EX entry, so a bubble clears it next cycle.
    always_comb begin
        hazard = valid_o && ctrl_q.mem_rd && (rd_o != '0) &&
                 ((rd_o == rs1) || (uses_rs2(op) && (rd_o == rs2)));
        bubble  = hazard || flush_i;
        stall_o = hazard && !flush_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i || bubble) begin
            valid_o    <= 1'b0;
            op_o       <= '0;
            rd_o       <= '0;
            rs1_addr_o <= '0;
            rs2_addr_o <= '0;
            rs1_data_o <= '0;
            rs2_data_o <= '0;
            imm_o      <= '0;
            next_pc_o  <= '0;
            ctrl_q     <= '0;
        end else begin
            valid_o    <= 1'b1;
            op_o       <= op;
            rd_o       <= rd;
            rs1_addr_o <= rs1;
            rs2_addr_o <= rs2;
            rs1_data_o <= rs1_data;
            rs2_data_o <= rs2_data;
            imm_o      <= imm;
            next_pc_o  <= next_pc_i;
            ctrl_q     <= ctrl_d;
        end
    end

    assign reg_we_o  = ctrl_q.reg_we;
    assign mem_rd_o  = ctrl_q.mem_rd;
    assign mem_wr_o  = ctrl_q.mem_wr;
    assign branch_o  = ctrl_q.branch;
    assign jump_o    = ctrl_q.jump;
    assign illegal_o = ctrl_q.illegal;

endmodule

// File: tb/tb_super_decode.sv
// Directed bench for super_decode; expectations follow DECODE_BYPASS_EN.
module tb_super_decode;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [15:0] next_pc_i;
    logic [15:0] instr_i;
    logic        flush_i;
    logic        wb_en_i;
    logic [3:0]  wb_addr_i;
    logic [15:0] wb_data_i;
    logic        stall_o, valid_o;
    logic [3:0]  op_o, rd_o, rs1_addr_o, rs2_addr_o;
    logic [15:0] rs1_data_o, rs2_data_o, imm_o, next_pc_o;
    logic        reg_we_o, mem_rd_o, mem_wr_o, branch_o, jump_o, illegal_o;

    int n_checks = 0;
    int n_fail   = 0;

    super_decode #(
        .REGI_BITS (4),
        .REGI_SIZE (16)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .next_pc_i  (next_pc_i),
        .instr_i    (instr_i),
        .flush_i    (flush_i),
        .wb_en_i    (wb_en_i),
        .wb_addr_i  (wb_addr_i),
        .wb_data_i  (wb_data_i),
        .stall_o    (stall_o),
        .valid_o    (valid_o),
        .op_o       (op_o),
        .rd_o       (rd_o),
        .rs1_addr_o (rs1_addr_o),
        .rs2_addr_o (rs2_addr_o),
        .rs1_data_o (rs1_data_o),
        .rs2_data_o (rs2_data_o),
        .imm_o      (imm_o),
        .next_pc_o  (next_pc_o),
        .reg_we_o   (reg_we_o),
        .mem_rd_o   (mem_rd_o),
        .mem_wr_o   (mem_wr_o),
        .branch_o   (branch_o),
        .jump_o     (jump_o),
        .illegal_o  (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    logic [15:0] bypass_exp;

    initial begin
`ifdef DECODE_BYPASS_EN
        bypass_exp = 16'hBEEF;
`else
        bypass_exp = 16'h0000;
`endif
        rst_i = 1'b1; instr_i = 16'h1123; next_pc_i = 16'h0001;
        flush_i = 1'b0; wb_en_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;

        // reset state
        #2;
        chk("rst_valid", valid_o, 0);
        chk("rst_op", op_o, 0);
        chk("rst_rd", rd_o, 0);
        chk("rst_reg_we", reg_we_o, 0);
        chk("rst_stall", stall_o, 0);
        tick();
        chk("rst_held_valid", valid_o, 0);
        rst_i = 1'b0;
        tick();
        chk("first_valid", valid_o, 1);
        chk("first_op", op_o, 1);
        chk("first_rd", rd_o, 1);
        chk("first_rs1", rs1_addr_o, 2);
        chk("first_rs2", rs2_addr_o, 3);
        chk("first_reg_we", reg_we_o, 1);
        chk("first_next_pc", next_pc_o, 16'h0001);

        // reset acts without waiting for an edge
        rst_i = 1'b1;
        #1;
        chk("async_rst_valid", valid_o, 0);
        chk("async_rst_reg_we", reg_we_o, 0);
        rst_i = 1'b0;

        // load-use hazard via rs1
        instr_i = 16'h5310; next_pc_i = 16'h0042;
        tick();
        chk("load_mem_rd", mem_rd_o, 1);
        chk("load_reg_we", reg_we_o, 1);
        chk("load_next_pc", next_pc_o, 16'h0042);
        instr_i = 16'h1434;
        #1;
        chk("hz_stall", stall_o, 1);
        tick();
        chk("hz_bubble_valid", valid_o, 0);
        chk("hz_bubble_mem_rd", mem_rd_o, 0);
        chk("hz_bubble_reg_we", reg_we_o, 0);
        chk("hz_stall_released", stall_o, 0);
        tick();
        chk("hz_add_valid", valid_o, 1);
        chk("hz_add_op", op_o, 1);
        chk("hz_add_rd", rd_o, 4);
        chk("hz_add_stall", stall_o, 0);

        // flush wins over the hazard
        instr_i = 16'h5310;
        tick();
        instr_i = 16'h1434; flush_i = 1'b1;
        #1;
        chk("fl_stall", stall_o, 0);
        tick();
        chk("fl_bubble_valid", valid_o, 0);
        flush_i = 1'b0;
        #1;
        chk("fl_no_extra_stall", stall_o, 0);
        tick();
        chk("fl_add_valid", valid_o, 1);

        // rs2 field matters only for opcodes that read rs2
        instr_i = 16'h5310;
        tick();
        instr_i = 16'h4113;
        #1;
        chk("addi_rs2_no_stall", stall_o, 0);
        instr_i = 16'h7013;
        #1;
        chk("beq_rs2_stall", stall_o, 1);
        instr_i = 16'h6013;
        #1;
        chk("store_rs2_stall", stall_o, 1);

        // reset during a stall drops it
        rst_i = 1'b1;
        #1;
        chk("rst_mid_stall", stall_o, 0);
        rst_i = 1'b0;

        // load to r0 never hazards
        instr_i = 16'h5010;
        tick();
        instr_i = 16'h1000;
        #1;
        chk("load_r0_no_stall", stall_o, 0);

        // write-back into the same-cycle read
        wb_en_i = 1'b1; wb_addr_i = 4'd5; wb_data_i = 16'hBEEF; instr_i = 16'h1050;
        tick();
        chk("wb_same_cycle_rs1", rs1_data_o, bypass_exp);
        wb_en_i = 1'b0; instr_i = 16'h1255;
        tick();
        chk("wb_later_rs1", rs1_data_o, 16'hBEEF);
        chk("wb_later_rs2", rs2_data_o, 16'hBEEF);

        // r0 stays zero
        wb_en_i = 1'b1; wb_addr_i = 4'd0; wb_data_i = 16'h1234; instr_i = 16'h1000;
        tick();
        chk("r0_same_cycle", rs1_data_o, 0);
        wb_en_i = 1'b0;
        tick();
        chk("r0_read", rs1_data_o, 0);

        // immediates and control decode
        instr_i = 16'h412F;
        tick();
        chk("addi_imm", imm_o, 16'hFFFF);
        chk("addi_reg_we", reg_we_o, 1);
        instr_i = 16'h8080;
        tick();
        chk("jmp_imm", imm_o, 16'hFF80);
        chk("jmp_jump", jump_o, 1);
        chk("jmp_reg_we", reg_we_o, 0);
        instr_i = 16'h7123;
        tick();
        chk("beq_branch", branch_o, 1);
        chk("beq_imm", imm_o, 16'h0003);
        instr_i = 16'h6017;
        tick();
        chk("store_mem_wr", mem_wr_o, 1);
        chk("store_imm", imm_o, 16'h0007);
        instr_i = 16'h1123;
        tick();
        chk("add_imm_zero", imm_o, 0);

        // illegal opcode
        instr_i = 16'hC000;
        tick();
        chk("ill_illegal", illegal_o, 1);
        chk("ill_valid", valid_o, 1);
        chk("ill_ctrl", {reg_we_o, mem_rd_o, mem_wr_o, branch_o, jump_o}, 0);

        // reset clears the register file
        rst_i = 1'b1;
        #1;
        rst_i = 1'b0;
        instr_i = 16'h1050;
        tick();
        chk("rf_cleared", rs1_data_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
